// File: rtl/uart_tx_sysclk.sv
// UART transmitter running entirely on i_sys_clk: a baud-tick counter, a one-word
// holding buffer and a frame serialiser (start, LSB-first data, optional parity, stop).
module uart_tx_sysclk #(
  parameter int P_SYSTEM_CLK      = 50000000,
  parameter int P_UART_BUADRATE   = 115200,
  parameter int P_UART_DATA_WIDTH = 8,
  parameter int P_UART_STOP_WIDTH = 1,
  parameter int P_UART_CHECK      = 0
) (
  input  logic                         i_sys_clk,
  input  logic                         i_sys_rst,
  input  logic [P_UART_DATA_WIDTH-1:0] i_user_tx_data,
  input  logic                         i_user_tx_valid,
  output logic                         o_user_tx_ready,
  output logic                         o_uart_tx,
  output logic                         o_tx_busy
);

  localparam int DIV   = P_SYSTEM_CLK / P_UART_BUADRATE;
  localparam int CNT_W = $clog2(DIV);
  localparam int BIT_W = $clog2(P_UART_DATA_WIDTH);

  localparam bit PAR_EN  = (P_UART_CHECK == 1) || (P_UART_CHECK == 2);
  localparam bit PAR_ODD = (P_UART_CHECK == 1);

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(P_UART_DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(P_UART_STOP_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                         state_q, state_d;
  logic [CNT_W-1:0]               baud_q, baud_d;
  logic [BIT_W-1:0]               bit_q, bit_d;
  logic [P_UART_DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [P_UART_DATA_WIDTH-1:0]   buf_data_q, buf_data_d;
  logic                           par_q, par_d;
  logic                           tx_q, tx_d;
  logic                           buf_full_q, buf_full_d;
  logic                           ready_q;
  logic                           baud_tick;
  logic                           load;

  assign baud_tick = (baud_q == BAUD_LAST);

  // NOTE: every variable gets its hold value first so no path through the case
  // statement leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_d      = par_q;
    tx_d       = tx_q;
    buf_full_d = buf_full_q;
    buf_data_d = buf_data_q;
    load       = 1'b0;

    // ready_q mirrors ~buf_full_q, so a capture never collides with the FSM load below.
    if (i_user_tx_valid && ready_q) begin
      buf_data_d = i_user_tx_data;
      buf_full_d = 1'b1;
    end

    if (state_q != S_IDLE) begin
      baud_d = baud_tick ? '0 : baud_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        load = buf_full_q;
      end
      S_START: begin
        if (baud_tick) begin
          state_d = S_DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (PAR_EN) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
      S_PARITY: begin
        if (baud_tick) begin
          state_d = S_STOP;
          bit_d   = '0;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        if (baud_tick) begin
          if (bit_q == STOP_LAST) begin
            // A waiting word chains straight into its start bit with no idle gap.
            if (buf_full_q) begin
              load = 1'b1;
            end else begin
              state_d = S_IDLE;
              bit_d   = '0;
            end
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    if (load) begin
      shift_d    = buf_data_q;
      par_d      = PAR_ODD ? ~(^buf_data_q) : ^buf_data_q;
      buf_full_d = 1'b0;
      state_d    = S_START;
      tx_d       = 1'b0;
      baud_d     = '0;
      bit_d      = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      tx_q       <= 1'b1;
      buf_full_q <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      tx_q       <= tx_d;
      buf_full_q <= buf_full_d;
      ready_q    <= ~buf_full_d;
    end
  end

  // NOTE: payload registers are deliberately not reset; buf_full_q and the state
  // register decide when their contents are used.
  always_ff @(posedge i_sys_clk) begin
    shift_q    <= shift_d;
    buf_data_q <= buf_data_d;
    par_q      <= par_d;
  end

  assign o_uart_tx       = tx_q;
  assign o_user_tx_ready = ready_q;
  assign o_tx_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_sysclk.sv
// Directed bench for uart_tx_sysclk: four instances (8N1, 8O1, 8E1, 8N2) at DIV=10
// checked against hand-derived line patterns.
module tb_uart_tx_sysclk;

  localparam int DIV = 10;

  // Line levels in time order, bit 0 first: start, data LSB first, [parity], stop(s).
  localparam logic [19:0] P_A5     = 20'b1101001010;
  localparam logic [19:0] P_55     = 20'b1010101010;
  localparam logic [19:0] P_AA     = 20'b1101010100;
  localparam logic [19:0] P_81     = 20'b1100000010;
  localparam logic [19:0] P_03_ODD = 20'b11000000110;
  localparam logic [19:0] P_03_EVN = 20'b10000000110;
  localparam logic [19:0] P_07_EVN = 20'b11000001110;
  localparam logic [19:0] P_FF_2SB = 20'b11111111110;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic [3:0] valid;
  logic [7:0] din [4];
  wire  [3:0] ready;
  wire  [3:0] tx;
  wire  [3:0] busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 sys_clk = ~sys_clk;

  uart_tx_sysclk #(.P_SYSTEM_CLK(1000000), .P_UART_BUADRATE(100000), .P_UART_DATA_WIDTH(8),
                   .P_UART_STOP_WIDTH(1), .P_UART_CHECK(0)) u_dut_8n1 (
    .i_sys_clk(sys_clk), .i_sys_rst(sys_rst), .i_user_tx_data(din[0]),
    .i_user_tx_valid(valid[0]), .o_user_tx_ready(ready[0]), .o_uart_tx(tx[0]), .o_tx_busy(busy[0]));

  uart_tx_sysclk #(.P_SYSTEM_CLK(1000000), .P_UART_BUADRATE(100000), .P_UART_DATA_WIDTH(8),
                   .P_UART_STOP_WIDTH(1), .P_UART_CHECK(1)) u_dut_8o1 (
    .i_sys_clk(sys_clk), .i_sys_rst(sys_rst), .i_user_tx_data(din[1]),
    .i_user_tx_valid(valid[1]), .o_user_tx_ready(ready[1]), .o_uart_tx(tx[1]), .o_tx_busy(busy[1]));

  uart_tx_sysclk #(.P_SYSTEM_CLK(1000000), .P_UART_BUADRATE(100000), .P_UART_DATA_WIDTH(8),
                   .P_UART_STOP_WIDTH(1), .P_UART_CHECK(2)) u_dut_8e1 (
    .i_sys_clk(sys_clk), .i_sys_rst(sys_rst), .i_user_tx_data(din[2]),
    .i_user_tx_valid(valid[2]), .o_user_tx_ready(ready[2]), .o_uart_tx(tx[2]), .o_tx_busy(busy[2]));

  uart_tx_sysclk #(.P_SYSTEM_CLK(1000000), .P_UART_BUADRATE(100000), .P_UART_DATA_WIDTH(8),
                   .P_UART_STOP_WIDTH(2), .P_UART_CHECK(0)) u_dut_8n2 (
    .i_sys_clk(sys_clk), .i_sys_rst(sys_rst), .i_user_tx_data(din[3]),
    .i_user_tx_valid(valid[3]), .o_user_tx_ready(ready[3]), .o_uart_tx(tx[3]), .o_tx_busy(busy[3]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Presents a word and returns #1 after the edge on which it was accepted.
  task automatic offer(input int idx, input logic [7:0] d);
    int waited = 0;
    @(negedge sys_clk);
    din[idx]   = d;
    valid[idx] = 1'b1;
    while (!ready[idx] && waited < 300) begin
      @(negedge sys_clk);
      waited++;
    end
    if (waited >= 300) check("hs_ready_timeout", ready[idx], 1);
    @(posedge sys_clk);
    #1 valid[idx] = 1'b0;
  endtask

  // Samples the line once per clock from sample index 'skip' onward, then checks idle.
  task automatic expect_line(input int idx, input logic [19:0] pat, input int nbits,
                             input int skip, input string tag);
    for (int s = skip; s < nbits * DIV; s++) begin
      @(negedge sys_clk);
      check({tag, "_tx"}, tx[idx], pat[s / DIV]);
      check({tag, "_busy"}, busy[idx], 1);
    end
    @(negedge sys_clk);
    check({tag, "_idle_tx"}, tx[idx], 1);
    check({tag, "_idle_busy"}, busy[idx], 0);
    check({tag, "_idle_ready"}, ready[idx], 1);
  endtask

  task automatic single_frame(input int idx, input logic [7:0] d, input logic [19:0] pat,
                              input int nbits, input string tag);
    offer(idx, d);
    @(negedge sys_clk);
    check({tag, "_lat_tx"}, tx[idx], 1);
    check({tag, "_lat_ready"}, ready[idx], 0);
    check({tag, "_lat_busy"}, busy[idx], 0);
    expect_line(idx, pat, nbits, 0, tag);
  endtask

  initial begin
    sys_rst = 1'b1;
    valid   = '0;
    for (int i = 0; i < 4; i++) din[i] = '0;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    for (int i = 0; i < 4; i++) begin
      check("rst_tx", tx[i], 1);
      check("rst_ready", ready[i], 1);
      check("rst_busy", busy[i], 0);
    end
    sys_rst = 1'b0;
    repeat (3) @(negedge sys_clk);

    // 8N1 basic frame, latency and bit timing.
    single_frame(0, 8'hA5, P_A5, 10, "a5_8n1");

    // Parity modes.
    single_frame(1, 8'h03, P_03_ODD, 11, "03_odd");
    single_frame(2, 8'h03, P_03_EVN, 11, "03_even");
    single_frame(2, 8'h07, P_07_EVN, 11, "07_even");

    // Two stop bits.
    single_frame(3, 8'hFF, P_FF_2SB, 11, "ff_2stop");

    // Back-to-back with valid held high: second word taken two edges after the first.
    @(negedge sys_clk);
    check("b2b_ready_pre", ready[0], 1);
    din[0]   = 8'h55;
    valid[0] = 1'b1;
    @(posedge sys_clk);
    #1 din[0] = 8'hAA;
    @(negedge sys_clk);
    check("b2b_ready_e0", ready[0], 0);
    check("b2b_tx_e0", tx[0], 1);
    @(negedge sys_clk);
    check("b2b_ready_e1", ready[0], 1);
    check("b2b_tx_e1", tx[0], 0);
    @(posedge sys_clk);
    #1 valid[0] = 1'b0;
    @(negedge sys_clk);
    check("b2b_ready_e2", ready[0], 0);
    check("b2b_tx_e2", tx[0], 0);
    expect_line(0, {P_AA[9:0], P_55[9:0]}, 20, 2, "b2b");

    // Buffer full: changing data under valid must not replace the captured word.
    @(negedge sys_clk);
    din[0]   = 8'hA5;
    valid[0] = 1'b1;
    @(posedge sys_clk);
    #1 din[0] = 8'h81;
    @(negedge sys_clk);
    check("hold_tx_e0", tx[0], 1);
    @(negedge sys_clk);
    check("hold_tx_e1", tx[0], 0);
    @(posedge sys_clk);
    #1;
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          din[0] = 8'h10 + 8'(i);
          @(negedge sys_clk);
          check("hold_ready_full", ready[0], 0);
          @(posedge sys_clk);
          #1;
        end
        valid[0] = 1'b0;
      end
      expect_line(0, {P_81[9:0], P_A5[9:0]}, 20, 1, "hold");
    join

    // Reset during data bit 3 of 0x00 with 0xFF waiting in the buffer.
    offer(0, 8'h00);
    offer(0, 8'hFF);
    repeat (42) @(posedge sys_clk);
    #2;
    check("abort_pre_tx", tx[0], 0);
    check("abort_pre_busy", busy[0], 1);
    check("abort_pre_ready", ready[0], 0);
    #1 sys_rst = 1'b1;
    #1;
    check("abort_tx", tx[0], 1);
    check("abort_ready", ready[0], 1);
    check("abort_busy", busy[0], 0);
    @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      check("post_rst_quiet_tx", tx[0], 1);
      check("post_rst_quiet_busy", busy[0], 0);
    end
    single_frame(0, 8'h81, P_81, 10, "post_rst_81");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
